// File: rtl/ram_pkg.sv
// Shared types for the scanning RAM slice.
// Engine state encoding, host command decode and default geometry.
package ram_pkg;

    localparam int RAM_WIDTH = 16;
    localparam int RAM_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SCAN,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_WR,
        CMD_RD
    } cmd_t;

    function automatic cmd_t host_cmd(
        input logic ce_n,
        input logic we_n,
        input logic oe_n
    );
        cmd_t cmd;
        cmd = CMD_NONE;
        unique case (1'b1)
            (!ce_n && !we_n):          cmd = CMD_WR;
            (!ce_n && we_n && !oe_n):  cmd = CMD_RD;
            default:                   cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Single-port synchronous storage array.
// Write and read both act on the rising edge; read data is registered.
module ram_sp_core
    import ram_pkg::*;
#(
    parameter int WIDTH  = RAM_WIDTH,
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_scan_max.sv
// Single-port RAM with an on-chip FILL / max-SCAN engine.
// The host path owns the array in IDLE; the engine owns it otherwise.
module ram_scan_max
    import ram_pkg::*;
#(
    parameter int              WIDTH      = RAM_WIDTH,
    parameter int              DEPTH      = RAM_DEPTH,
    parameter int              ADDR_W     = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] FILL_VALUE = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_n,
    input  logic              we_n,
    input  logic              oe_n,
    input  logic [ADDR_W-1:0] adrs,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              rd_valid,
    input  logic              fill_start,
    input  logic              scan_start,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  max_value,
    output logic [ADDR_W-1:0] max_adrs
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              rd_valid_q;
    logic              cmp_valid_q;
    logic [ADDR_W-1:0] cmp_adrs_q;
    logic [WIDTH-1:0]  max_value_q;
    logic [ADDR_W-1:0] max_adrs_q;
    logic [WIDTH-1:0]  data_hold_q;

    cmd_t              cmd;
    logic              host_wr, host_rd;
    logic              eng_we, eng_re;
    logic              clr_max;

    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  core_rdata;

    assign cmd     = host_cmd(ce_n, we_n, oe_n);
    assign host_wr = (state_q == IDLE) && (cmd == CMD_WR);
    assign host_rd = (state_q == IDLE) && (cmd == CMD_RD);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        eng_we  = 1'b0;
        eng_re  = 1'b0;
        clr_max = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    ptr_d   = '0;
                end else if (scan_start) begin
                    state_d = SCAN;
                    ptr_d   = '0;
                    clr_max = 1'b1;
                end
            end
            FILL: begin
                eng_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                    done_d  = 1'b1;
                end
            end
            SCAN: begin
                eng_re = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = DRAIN;
                    ptr_d   = '0;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Nothing reaches the array while reset is asserted.
    assign mem_we    = !rst && (host_wr || eng_we);
    assign mem_re    = host_rd || eng_re;
    assign mem_addr  = (state_q == IDLE) ? adrs : ptr_q;
    assign mem_wdata = (state_q == IDLE) ? data_in : FILL_VALUE;

    ram_sp_core #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_adrs_q  <= '0;
            max_value_q <= '0;
            max_adrs_q  <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            rd_valid_q  <= host_rd;
            cmp_valid_q <= eng_re;
            cmp_adrs_q  <= ptr_q;
            data_hold_q <= data_out;
            // Strict compare keeps the lowest address on ties.
            if (clr_max) begin
                max_value_q <= '0;
                max_adrs_q  <= '0;
            end else if (cmp_valid_q &&
                         core_rdata > max_value_q) begin
                max_value_q <= core_rdata;
                max_adrs_q  <= cmp_adrs_q;
            end
        end
    end

    // The array read register is shared with the engine, so host data
    // is taken from it only on the valid cycle and held otherwise.
    assign data_out  = rd_valid_q ? core_rdata : data_hold_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign max_value = max_value_q;
    assign max_adrs  = max_adrs_q;

endmodule

// File: tb/tb_ram_scan_max.sv
// Bench for ram_scan_max: three geometries behind one selectable host port.
// Expected values come from a plain array model of memory contents.
module tb_ram_scan_max;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_n = 1'b1;
    logic        we_n = 1'b1;
    logic        oe_n = 1'b1;
    logic [6:0]  adrs = '0;
    logic [15:0] data_in = '0;
    logic        fill_start = 1'b0;
    logic        scan_start = 1'b0;
    logic [1:0]  sel = 2'd0;

    logic [15:0] do_a, do_b, mv_a, mv_b;
    logic [7:0]  do_c, mv_c;
    logic [6:0]  ma_a, ma_b, ma_c;
    logic        rv_a, rv_b, rv_c;
    logic        bz_a, bz_b, bz_c;
    logic        dn_a, dn_b, dn_c;

    logic [15:0] data_out, max_value;
    logic [6:0]  max_adrs;
    logic        rd_valid, busy, done;

    int passed = 0;
    int total  = 0;

    logic [15:0] mem_m [3][128];
    int          dep   [3] = '{128, 128, 100};
    logic [15:0] mask  [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
    logic [15:0] fillv [3] = '{16'hFFFF, 16'h0000, 16'h0000};

    always #5 clk = ~clk;

    ram_scan_max u_a (
        .clk(clk), .rst(rst),
        .ce_n(ce_n | (sel != 2'd0)), .we_n(we_n), .oe_n(oe_n),
        .adrs(adrs), .data_in(data_in),
        .data_out(do_a), .rd_valid(rv_a),
        .fill_start(fill_start & (sel == 2'd0)),
        .scan_start(scan_start & (sel == 2'd0)),
        .busy(bz_a), .done(dn_a),
        .max_value(mv_a), .max_adrs(ma_a)
    );

    ram_scan_max #(.FILL_VALUE(16'h0000)) u_b (
        .clk(clk), .rst(rst),
        .ce_n(ce_n | (sel != 2'd1)), .we_n(we_n), .oe_n(oe_n),
        .adrs(adrs), .data_in(data_in),
        .data_out(do_b), .rd_valid(rv_b),
        .fill_start(fill_start & (sel == 2'd1)),
        .scan_start(scan_start & (sel == 2'd1)),
        .busy(bz_b), .done(dn_b),
        .max_value(mv_b), .max_adrs(ma_b)
    );

    ram_scan_max #(
        .WIDTH(8), .DEPTH(100), .FILL_VALUE(8'h00)
    ) u_c (
        .clk(clk), .rst(rst),
        .ce_n(ce_n | (sel != 2'd2)), .we_n(we_n), .oe_n(oe_n),
        .adrs(adrs), .data_in(data_in[7:0]),
        .data_out(do_c), .rd_valid(rv_c),
        .fill_start(fill_start & (sel == 2'd2)),
        .scan_start(scan_start & (sel == 2'd2)),
        .busy(bz_c), .done(dn_c),
        .max_value(mv_c), .max_adrs(ma_c)
    );

    always_comb begin
        data_out  = do_a;
        rd_valid  = rv_a;
        busy      = bz_a;
        done      = dn_a;
        max_value = mv_a;
        max_adrs  = ma_a;
        case (sel)
            2'd1: begin
                data_out  = do_b;
                rd_valid  = rv_b;
                busy      = bz_b;
                done      = dn_b;
                max_value = mv_b;
                max_adrs  = ma_b;
            end
            2'd2: begin
                data_out  = {8'h00, do_c};
                rd_valid  = rv_c;
                busy      = bz_c;
                done      = dn_c;
                max_value = {8'h00, mv_c};
                max_adrs  = ma_c;
            end
            default: ;
        endcase
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input bit ce, input bit we, input bit oe,
                        input int a, input logic [15:0] d);
        ce_n = ce;
        we_n = we;
        oe_n = oe;
        adrs = a[6:0];
        data_in = d;
        tick();
        ce_n = 1'b1;
        we_n = 1'b1;
        oe_n = 1'b1;
        if (!ce && !we) mem_m[sel][a] = d & mask[sel];
    endtask

    function automatic void model_max(input int s,
                                      output logic [15:0] mv,
                                      output logic [6:0] ma);
        mv = '0;
        ma = '0;
        for (int i = 0; i < dep[s]; i++) begin
            if (mem_m[s][i] > mv) begin
                mv = mem_m[s][i];
                ma = i[6:0];
            end
        end
    endfunction

    task automatic model_fill(input int s);
        for (int i = 0; i < dep[s]; i++) mem_m[s][i] = fillv[s];
    endtask

    // Start the engine, count busy cycles, check the done pulse shape.
    task automatic run_engine(input int s, input bit f, input bit sc,
                              input bit inj, input int exp_busy,
                              input string nm);
        int cnt;
        int early;
        sel = s[1:0];
        fill_start = f;
        scan_start = sc;
        tick();
        fill_start = 1'b0;
        scan_start = 1'b0;
        cnt = 0;
        early = 0;
        while (busy && cnt < 400) begin
            if (inj && cnt == 5) begin
                ce_n = 1'b0;
                we_n = 1'b0;
                adrs = 7'd3;
                data_in = 16'hFFFF;
                fill_start = 1'b1;
            end else begin
                ce_n = 1'b1;
                we_n = 1'b1;
                fill_start = 1'b0;
            end
            if (done || rd_valid) early++;
            cnt++;
            tick();
        end
        ce_n = 1'b1;
        we_n = 1'b1;
        fill_start = 1'b0;
        check({nm, "_busy_cycles"}, cnt, exp_busy);
        check({nm, "_stray_pulse"}, early, 0);
        check({nm, "_done"}, {31'd0, done}, 1);
        tick();
        check({nm, "_done_once"}, {31'd0, done}, 0);
        check({nm, "_no_requeue"}, {31'd0, busy}, 0);
    endtask

    task automatic scan_check(input int s, input string nm);
        logic [15:0] mv;
        logic [6:0]  ma;
        run_engine(s, 1'b0, 1'b1, 1'b0, dep[s] + 1, nm);
        model_max(s, mv, ma);
        check({nm, "_max_value"}, {16'd0, max_value}, {16'd0, mv});
        check({nm, "_max_adrs"}, {25'd0, max_adrs}, {25'd0, ma});
    endtask

    task automatic reset_mid_scan(input int s, input string nm);
        sel = s[1:0];
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (39) tick();
        check({nm, "_busy_before"}, {31'd0, busy}, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check({nm, "_busy"}, {31'd0, busy}, 0);
        check({nm, "_done"}, {31'd0, done}, 0);
        check({nm, "_max_value"}, {16'd0, max_value}, 0);
        check({nm, "_max_adrs"}, {25'd0, max_adrs}, 0);
        check({nm, "_data_out"}, {16'd0, data_out}, 0);
        tick();
        check({nm, "_no_done"}, {31'd0, done}, 0);
        scan_check(s, {nm, "_rescan"});
    endtask

    typedef struct {
        bit          ce;
        bit          we;
        bit          oe;
        int          a;
        logic [15:0] d;
        bit          rv;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b1, 7,   16'hA5A5, 1'b0, 16'h0000};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 7,   16'h0000, 1'b1, 16'hA5A5};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8,   16'h0000, 1'b0, 16'hA5A5};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 7,   16'h0000, 1'b0, 16'hA5A5};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8,   16'h0000, 1'b1, 16'hFFFF};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 9,   16'h5A5A, 1'b0, 16'hFFFF};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 9,   16'h0000, 1'b1, 16'h5A5A};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 7,   16'h0000, 1'b1, 16'hA5A5};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 127, 16'h0000, 1'b1, 16'hFFFF};

        repeat (2) tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s[1:0];
            #1;
            check($sformatf("rst%0d_busy", s), {31'd0, busy}, 0);
            check($sformatf("rst%0d_done", s), {31'd0, done}, 0);
            check($sformatf("rst%0d_rv", s), {31'd0, rd_valid}, 0);
            check($sformatf("rst%0d_dout", s), {16'd0, data_out}, 0);
            check($sformatf("rst%0d_maxv", s), {16'd0, max_value}, 0);
            check($sformatf("rst%0d_maxa", s), {25'd0, max_adrs}, 0);
        end

        // Both starts together: FILL wins, scan results untouched.
        run_engine(1, 1'b1, 1'b1, 1'b0, 128, "simul");
        model_fill(1);
        check("simul_max_value", {16'd0, max_value}, 0);
        check("simul_max_adrs", {25'd0, max_adrs}, 0);

        run_engine(0, 1'b1, 1'b0, 1'b0, 128, "fill_a");
        model_fill(0);
        scan_check(0, "tie_a");
        check("tie_a_lit_value", {16'd0, max_value}, 32'hFFFF);
        check("tie_a_lit_adrs", {25'd0, max_adrs}, 0);

        sel = 2'd0;
        for (int i = 0; i < 9; i++) begin
            host(tbl[i].ce, tbl[i].we, tbl[i].oe, tbl[i].a, tbl[i].d);
            check($sformatf("tbl%0d_rv", i), {31'd0, rd_valid},
                  {31'd0, tbl[i].rv});
            check($sformatf("tbl%0d_dout", i), {16'd0, data_out},
                  {16'd0, tbl[i].dout});
        end
        tick();
        check("rv_one_cycle", {31'd0, rd_valid}, 0);

        sel = 2'd1;
        host(1'b0, 1'b0, 1'b1, 5, 16'h1234);
        host(1'b0, 1'b0, 1'b1, 127, 16'hBEEF);
        scan_check(1, "last_adrs");
        check("last_lit_value", {16'd0, max_value}, 32'hBEEF);
        check("last_lit_adrs", {25'd0, max_adrs}, 127);

        scan_check(1, "lock_pre");
        run_engine(1, 1'b0, 1'b1, 1'b1, 129, "lock");
        check("lock_max_value", {16'd0, max_value}, 32'hBEEF);
        check("lock_max_adrs", {25'd0, max_adrs}, 127);
        host(1'b0, 1'b1, 1'b0, 3, 16'h0000);
        check("lock_rd_rv", {31'd0, rd_valid}, 1);
        check("lock_rd_mem3", {16'd0, data_out}, {16'd0, mem_m[1][3]});

        run_engine(2, 1'b1, 1'b0, 1'b0, 100, "fill_c");
        model_fill(2);
        scan_check(2, "zero_c");

        for (int s = 1; s < 3; s++) begin
            sel = s[1:0];
            for (int k = 0; k < 24; k++) begin
                host(1'b0, 1'b0, 1'b1,
                     int'($urandom_range(0, dep[s] - 1)),
                     16'($urandom));
            end
            for (int k = 0; k < 8; k++) begin
                int a;
                a = int'($urandom_range(0, dep[s] - 1));
                host(1'b0, 1'b1, 1'b0, a, 16'h0000);
                check($sformatf("rnd%0d_rd%0d", s, k),
                      {16'd0, data_out}, {16'd0, mem_m[s][a]});
            end
            scan_check(s, $sformatf("rnd%0d_scan", s));
        end

        reset_mid_scan(1, "rms_b");
        reset_mid_scan(2, "rms_c");

        for (int s = 1; s < 3; s++) begin
            sel = s[1:0];
            host(1'b0, 1'b0, 1'b1, 90, mask[s]);
            host(1'b0, 1'b0, 1'b1, 30, mask[s]);
            scan_check(s, $sformatf("tie%0d", s));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_scan_max.md
Name: ram_scan_max

Overview:
- Parametrised synchronous single-port RAM (DEPTH x WIDTH), successor to the fixed 128x16 asynchronous RAM.
- Adds an on-chip engine with two modes. FILL writes FILL_VALUE to every cell. SCAN reads every cell and reports the largest unsigned value and its address.
- Sits between a host bus and storage. Bring-up benches and the system controller use it to initialise memory and to find its maximum without per-address host traffic.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 128, number of words (>=2).
- ADDR_W, $clog2(DEPTH), address width.
- FILL_VALUE, {WIDTH{1'b1}}, word written by the FILL engine.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ce_n  in  1  host chip enable, active-low.
- we_n  in  1  host write enable, active-low.
- oe_n  in  1  host output enable, active-low.
- adrs  in  ADDR_W  host address.
- data_in  in  WIDTH  host write data.
- data_out  out  WIDTH  registered host read data.
- rd_valid  out  1  one-cycle pulse: data_out updated this cycle.
- fill_start  in  1  pulse: start FILL.
- scan_start  in  1  pulse: start SCAN.
- busy  out  1  engine active; host access ignored.
- done  out  1  one-cycle pulse: engine finished.
- max_value  out  WIDTH  largest word found by last SCAN.
- max_adrs  out  ADDR_W  address of max_value.

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE.
  - data_out, rd_valid, busy, done, max_value and max_adrs all go to 0.
  - Memory contents are not cleared.
  - Reset mid-FILL/SCAN aborts immediately. Cells already written stay written. No done pulse.
- Host port, only in IDLE:
  - Write: ce_n=0, we_n=0 writes data_in to mem[adrs] at the edge. oe_n is don't-care.
  - Read: ce_n=0, we_n=1, oe_n=0 gives data_out=mem[adrs] and rd_valid=1 on the next cycle (1-cycle latency). Otherwise rd_valid=0 and data_out holds its value.
  - ce_n=1 means no access.
- Host accesses while busy=1 are dropped silently: no write, no rd_valid.
- FSM states: IDLE, FILL, SCAN, DRAIN.
- IDLE transitions:
  - fill_start=1 goes to FILL with ptr=0.
  - Otherwise scan_start=1 goes to SCAN with ptr=0, max_value=0, max_adrs=0.
  - If both are asserted, FILL wins and scan_start is dropped.
  - A start pulse in the same cycle as a host access: the host access executes that cycle, then the engine starts.
- FILL:
  - Each cycle writes FILL_VALUE to mem[ptr] and increments ptr.
  - After the ptr=DEPTH-1 write, goes to IDLE.
  - busy is high for exactly DEPTH cycles.
- SCAN:
  - Each cycle issues a read of mem[ptr] and increments ptr.
  - Compares each returned word one cycle later: if word > max_value (strict, unsigned), update max_value and max_adrs. Ties keep the lowest address.
  - After issuing ptr=DEPTH-1, goes to DRAIN.
- DRAIN: compares the final word, then goes to IDLE. busy is high for DEPTH+1 cycles for a SCAN.
- done: one-cycle pulse in the first cycle after busy falls.
- max_value/max_adrs:
  - Valid when done pulses; hold until the next scan_start.
  - Updated during a scan, with no intermediate guarantee.
  - An all-zero memory gives max_value=0, max_adrs=0.
- Start pulses arriving while busy are ignored, not queued.
- ptr never wraps past DEPTH-1 within an operation. Non-power-of-two DEPTH is supported.

Decomposition:
- Shared package ram_pkg holds:
  - state typedef (IDLE/FILL/SCAN/DRAIN);
  - host command decode constants (CMD_NONE/CMD_WR/CMD_RD);
  - default WIDTH/DEPTH.
- One sub-module, ram_sp_core: parametrised synchronous single-port array with 1-cycle registered read and a write-enable. ram_scan_max muxes the host path or the engine path onto it.

Test Plan:
- Fill-then-scan tie: fill_start, wait for done (busy 128 cycles), then scan_start -> max_value=16'hFFFF, max_adrs=0, busy 129 cycles.
- Last-address boundary: WIDTH=16, DEPTH=128, FILL_VALUE=0; fill; host write 16'h1234@5 and 16'hBEEF@127; scan -> max_value=16'hBEEF, max_adrs=127 (proves DRAIN).
- Host read latency: write 16'hA5A5@7; read @7 -> data_out=16'hA5A5 with rd_valid one cycle later. oe_n=1 read -> no rd_valid.
- Busy lockout: during SCAN, write 16'hFFFF@3 and pulse fill_start -> neither takes effect; one done only; mem[3] unchanged on readback.
- Simultaneous start: fill_start and scan_start in the same cycle -> FILL runs, busy 128 cycles, max_* stay 0.
- Reset mid-scan: rst at cycle 40 of SCAN -> next cycle busy=0, done=0, max_value=0, max_adrs=0. A subsequent scan completes correctly. Repeat with DEPTH=100, WIDTH=8.
